apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_master_timeout.sv | 38 +++
 rtl/apb_master.sv | 145 ++++++++++++++
 tb/tb_apb_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its timeout counter.
package apb_pkg;

    localparam int unsigned APB_TIMEOUT_DEF    = 16;
    localparam int unsigned APB_ADDR_WIDTH_DEF = 32;
    localparam int unsigned APB_DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                          write;
        logic [APB_ADDR_WIDTH_DEF-1:0] addr;
        logic [APB_DATA_WIDTH_DEF-1:0] wdata;
    } apb_cmd_t;

    // Counter width able to hold 0..t; a disabled timeout (t = 0) still gets one bit.
    function automatic int unsigned apb_cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_master_timeout.sv
// ACCESS-phase wait-state counter; expired_o flags the last permitted wait cycle.
module apb_master_timeout
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = apb_cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] LastCnt = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == LastCnt);

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one SETUP/ACCESS transfer per accepted command, one response pulse per
// command, with a bounded ACCESS phase so an unresponsive slave cannot stall the requester.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT    = APB_TIMEOUT_DEF
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    apb_state_e state_q, state_d;

    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic done;
    logic abort;
    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    assign cmd_ready = (state_q == IDLE) && !PRESET;
    assign accept    = cmd_valid && cmd_ready;

    // Clearing during SETUP means the count starts at 0 in the first ACCESS cycle.
    assign tmo_clear  = (state_q == SETUP);
    assign tmo_enable = (state_q == ACCESS) && !PREADY;

    apb_master_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // PREADY takes priority over an expiry on the same edge.
                if (PREADY) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_expired) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        psel_d      = (state_d != IDLE);
        penable_d   = (state_d == ACCESS);
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = done || abort;
        rsp_err_d   = abort;
        rsp_rdata_d = '0;
        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
        end
        if (done && !pwrite_q) begin
            rsp_rdata_d = PRDATA;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: the driver queues expected responses, a monitor checks them.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY;
    logic [DW-1:0] PRDATA;

    apb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        int          plen;
    } exp_t;

    exp_t        sb[$];
    int          accs[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    apb_cmd_t    cur = '0;
    int          slave_waits = 0;   // -1: never ready
    logic [31:0] slave_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slave model: drives PREADY/PRDATA at negedge, garbage PRDATA during wait states.
    initial begin
        int w;
        w      = 0;
        PREADY = 1'b1;
        PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSEL && PENABLE) begin
                if (slave_waits >= 0 && w == slave_waits) begin
                    PREADY = 1'b1;
                    PRDATA = slave_rd;
                end else begin
                    PREADY = 1'b0;
                    PRDATA = $urandom;
                    w++;
                end
            end else begin
                w      = 0;
                PREADY = 1'b1;
                PRDATA = 32'hA5A5_5A5A;
            end
        end
    end

    // Monitor: bus stability, cmd_ready while busy, and response scoreboard.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge PCLK);
            if (PRESET) begin
                run = 0;
            end else begin
                if (PSEL) begin
                    check("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
                    check("paddr_stable", PADDR, cur.addr);
                    check("pwrite_stable", {31'b0, PWRITE}, {31'b0, cur.write});
                    if (cur.write) check("pwdata_stable", PWDATA, cur.wdata);
                end
                if (PENABLE) begin
                    run++;
                end else begin
                    if (rsp_valid) begin
                        if (sb.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected_rsp: got rsp_valid=1, want no response (t=%0t)",
                                     $time);
                        end else begin
                            e = sb.pop_front();
                            check("rsp_cycle", cyc, e.cyc);
                            check("rsp_rdata", rsp_rdata, e.rdata);
                            check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                            check("penable_len", run, e.plen);
                            check("psel_after", {31'b0, PSEL}, 32'd0);
                        end
                    end
                    run = 0;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge, cmd_valid still high.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input logic [31:0] rd, input logic err);
        int   n;
        int   lat;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got cmd_ready=0 for 100 cycles, want 1");
            cmd_valid = 1'b0;
            return;
        end
        cur.write   = w;
        cur.addr    = a;
        cur.wdata   = d;
        slave_waits = waits;
        slave_rd    = rd;
        lat         = (waits < 0) ? TO - 1 : waits;
        e.cyc       = cyc + 1 + 2 + lat;
        e.err       = err;
        e.rdata     = (err || w) ? 32'h0 : rd;
        e.plen      = lat + 1;
        sb.push_back(e);
        accs.push_back(cyc + 1);
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rel;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        #12;
        check("rst_psel", {31'b0, PSEL}, 32'd0);
        check("rst_penable", {31'b0, PENABLE}, 32'd0);
        check("rst_pwrite", {31'b0, PWRITE}, 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("cmd_ready_after_rst", {31'b0, cmd_ready}, 32'd1);
        @(negedge PCLK);

        // Write, zero waits; slave read data must not leak into a write response.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'h1111_2222, 1'b0);
        cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);

        // Read with 2 wait states.
        issue(1'b0, 32'h24, 32'h0, 2, 32'h12345678, 1'b0);
        cmd_valid = 1'b0;
        repeat (7) @(negedge PCLK);

        // Silent slave: abort after 16 ACCESS cycles.
        issue(1'b0, 32'h30, 32'h0, -1, 32'hFFFF_FFFF, 1'b1);
        cmd_valid = 1'b0;
        repeat (22) @(negedge PCLK);

        // PREADY on the 16th ACCESS cycle completes normally.
        issue(1'b0, 32'h34, 32'h0, 15, 32'hCAFEF00D, 1'b0);
        cmd_valid = 1'b0;
        repeat (22) @(negedge PCLK);

        // Back-to-back with cmd_valid held high.
        accs.delete();
        issue(1'b1, 32'h40, 32'h0000_0001, 0, 32'h3333_4444, 1'b0);
        issue(1'b0, 32'h44, 32'h0, 0, 32'h0BADC0DE, 1'b0);
        issue(1'b1, 32'h48, 32'h0000_0003, 0, 32'h5555_6666, 1'b0);
        cmd_valid = 1'b0;
        if (accs.size() == 3) begin
            check("b2b_gap_1", accs[1] - accs[0], 32'd3);
            check("b2b_gap_2", accs[2] - accs[1], 32'd3);
        end
        repeat (5) @(negedge PCLK);

        // Reset in the middle of ACCESS: no response, immediate re-accept.
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 32'h50;
        cmd_wdata   = 32'h0000_0077;
        cur.write   = 1'b1;
        cur.addr    = 32'h50;
        cur.wdata   = 32'h0000_0077;
        slave_waits = -1;
        @(posedge PCLK);
        #1 cmd_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("pre_rst_penable", {31'b0, PENABLE}, 32'd1);
        #2 PRESET = 1'b1;
        #1;
        check("mid_rst_psel", {31'b0, PSEL}, 32'd0);
        check("mid_rst_penable", {31'b0, PENABLE}, 32'd0);
        check("mid_rst_paddr", PADDR, 32'd0);
        check("mid_rst_pwdata", PWDATA, 32'd0);
        check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("cmd_ready_post_rst", {31'b0, cmd_ready}, 32'd1);
        rel = cyc;
        accs.delete();
        issue(1'b0, 32'h54, 32'h0, 1, 32'h600DF00D, 1'b0);
        cmd_valid = 1'b0;
        if (accs.size() == 1) check("post_rst_accept_cycle", accs[0], rel + 1);

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge PCLK);
            n++;
        end
        check("sb_drained", sb.size(), 32'd0);
        repeat (3) @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
